aibcr3_dcc_crsgry_ctrl: RTL

Coarse-delay controller for the DCC/DLL coarse delay line. Integrates phase-detector early/late decisions into an 8-bit binary coarse code that saturates at both ends. It drives the Gray-coded tap select `gry[10:3]` consumed by the coarse delay line's Gray-to-thermometer decoders. The block allows the line to settle after every code step and declares lock once the loop dithers around one tap.

---
 rtl/aibcr3_dcc_pkg.sv | 37 +++
 rtl/aibcr3_dcc_crs_integ.sv | 53 +++++
 rtl/aibcr3_dcc_crsgry_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/aibcr3_dcc_pkg.sv
// ---------------------------------------------------------------------------
// aibcr3_dcc_pkg
// Shared types and helpers for the DCC/DLL coarse-delay controller:
//   - crs_state_t : controller FSM states (IDLE, TRACK, SETTLE, LOCKED)
//   - crs_dir_t   : direction of the last code step (none / up / down)
//   - CRS_CODE_W / CRS_CODE_MAX : width and ceiling of the binary coarse code
//   - UNLOCK_RUN  : same-direction steps in a row that drop lock
//   - INTEG_TRIP  : integrator magnitude that releases a filtered step
//   - bin2gry()   : binary to reflected Gray conversion
// ---------------------------------------------------------------------------
package aibcr3_dcc_pkg;

  localparam int                    CRS_CODE_W   = 8;
  localparam logic [CRS_CODE_W-1:0] CRS_CODE_MAX = 8'd255;
  localparam int                    UNLOCK_RUN   = 4;
  localparam int                    INTEG_TRIP   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_SETTLE,
    ST_LOCKED
  } crs_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } crs_dir_t;

  // Adjacent binary codes map to Gray codes that differ in a single bit,
  // which keeps the delay-line thermometer decoders glitch-free.
  function automatic logic [CRS_CODE_W-1:0] bin2gry(input logic [CRS_CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/aibcr3_dcc_crs_integ.sv
// ---------------------------------------------------------------------------
// aibcr3_dcc_crs_integ
// Phase-detector sample qualifier plus signed integrator. Only built when
// AIBCR3_DCC_CRS_FILTER_EN is defined. Every qualified sample moves the
// integrator one count; a step is released when it would reach +/-INTEG_TRIP,
// and the integrator restarts from zero.
// Ports:
//   i_clk     clock
//   i_rstb    synchronous active-low reset
//   i_clr     synchronous clear (loop disabled)
//   i_accept  controller is in a state that accepts samples
//   i_pdVld   phase-detector strobe
//   i_pdUp    phase-detector "delay too short"
//   i_pdDn    phase-detector "delay too long"
//   o_step    filtered step request (combinational, same cycle as sample)
//   o_up      direction of o_step (1 = up)
// ---------------------------------------------------------------------------
module aibcr3_dcc_crs_integ
  import aibcr3_dcc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstb,
  input  logic i_clr,
  input  logic i_accept,
  input  logic i_pdVld,
  input  logic i_pdUp,
  input  logic i_pdDn,
  output logic o_step,
  output logic o_up
);

  localparam logic signed [2:0] ACC_TOP = 3'(INTEG_TRIP - 1);

  logic signed [2:0] r_acc;
  logic              w_sample;

  assign w_sample = i_accept && i_pdVld && (i_pdUp ^ i_pdDn);
  assign o_up     = i_pdUp;

  // The stored value never leaves -3..+3: the sample that would reach the
  // trip level fires the step instead of being stored.
  assign o_step   = w_sample && (i_pdUp ? (r_acc == ACC_TOP) : (r_acc == -ACC_TOP));

  // Integrator register: cleared on reset, loop disable, or a released step.
  always_ff @(posedge i_clk) begin
    if (!i_rstb || i_clr || o_step) begin
      r_acc <= '0;
    end else if (w_sample) begin
      r_acc <= i_pdUp ? (r_acc + 3'sd1) : (r_acc - 3'sd1);
    end
  end

endmodule

// File: rtl/aibcr3_dcc_crsgry_ctrl.sv
// ---------------------------------------------------------------------------
// aibcr3_dcc_crsgry_ctrl
// Coarse-delay controller: integrates phase-detector up/down decisions into
// a saturating 8-bit code, drives its Gray form to the coarse delay line,
// waits SETTLE_CYC cycles after each step and flags lock once the loop
// dithers around one tap.
// Optional macro AIBCR3_DCC_CRS_FILTER_EN: route samples through a +/-4
// integrator (aibcr3_dcc_crs_integ) instead of stepping on every sample.
// Ports:
//   CLK       clock
//   RSTb      synchronous active-low reset
//   en        loop enable (level)
//   pd_vld    phase-detector sample strobe
//   pd_up     request code+1 (qualified by pd_vld)
//   pd_dn     request code-1 (qualified by pd_vld)
//   gry       registered Gray code of bin_code
//   bin_code  current binary coarse code
//   locked    loop locked
//   sat_hi    code is 255
//   sat_lo    code is 0
//   busy      settling after a step
// ---------------------------------------------------------------------------
module aibcr3_dcc_crsgry_ctrl
  import aibcr3_dcc_pkg::*;
#(
  parameter logic [CRS_CODE_W-1:0] INIT_CODE    = 8'd128,
  parameter int                    SETTLE_CYC   = 7,
  parameter int                    LOCK_TOGGLES = 4
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic                  en,
  input  logic                  pd_vld,
  input  logic                  pd_up,
  input  logic                  pd_dn,
  output logic [10:3]           gry,
  output logic [CRS_CODE_W-1:0] bin_code,
  output logic                  locked,
  output logic                  sat_hi,
  output logic                  sat_lo,
  output logic                  busy
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] LOCK_TOG    = 3'(LOCK_TOGGLES);
  localparam logic [2:0] UNLOCK_PRE  = 3'(UNLOCK_RUN - 1);

  crs_state_t            r_state, w_stateNext;
  logic [CRS_CODE_W-1:0] r_code, w_codeNext;
  logic [10:3]           r_gry;
  logic                  r_locked, w_lockedNext;
  logic                  r_busy, r_satHi, r_satLo;
  logic [3:0]            r_settleCnt, w_settleCntNext;
  logic [2:0]            r_togCnt, w_togCntNext;
  logic [2:0]            r_runCnt, w_runCntNext;
  crs_dir_t              r_lastDir, w_lastDirNext, w_dir;
  logic                  w_settleDone, w_accept, w_exitLock, w_step, w_up;

  // The last SETTLE cycle already accepts a sample, so the first accepted
  // sample lands on the same edge that busy falls.
  assign w_settleDone = (r_state == ST_SETTLE) && (r_settleCnt == 4'd0);
  assign w_accept     = en && ((r_state == ST_TRACK) || (r_state == ST_LOCKED) || w_settleDone);
  assign w_exitLock   = r_locked || (r_togCnt >= LOCK_TOG);
  assign w_dir        = w_up ? DIR_UP : DIR_DN;

`ifdef AIBCR3_DCC_CRS_FILTER_EN
  aibcr3_dcc_crs_integ u_integ (
    .i_clk    (CLK),
    .i_rstb   (RSTb),
    .i_clr    (~en),
    .i_accept (w_accept),
    .i_pdVld  (pd_vld),
    .i_pdUp   (pd_up),
    .i_pdDn   (pd_dn),
    .o_step   (w_step),
    .o_up     (w_up)
  );
`else
  assign w_step = w_accept && pd_vld && (pd_up ^ pd_dn);
  assign w_up   = pd_up;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: disable wins over everything, a step always (re)enters
  // SETTLE, and SETTLE exits to LOCKED when lock is held or newly earned.
  always_comb begin
    w_stateNext = r_state;
    if (!en) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_stateNext = ST_TRACK;
        ST_TRACK:  if (w_step) w_stateNext = ST_SETTLE;
        ST_SETTLE: begin
          if (w_step) begin
            w_stateNext = ST_SETTLE;
          end else if (w_settleDone) begin
            w_stateNext = w_exitLock ? ST_LOCKED : ST_TRACK;
          end
        end
        ST_LOCKED: if (w_step) w_stateNext = ST_SETTLE;
        default:   w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: saturating code, settle countdown, and the
  // direction history that drives lock (reversal count) and unlock (run of
  // same-direction steps). Lock is evaluated at SETTLE exit before any step
  // taken in that same cycle can clear it again.
  always_comb begin
    w_codeNext      = r_code;
    w_lockedNext    = r_locked;
    w_settleCntNext = r_settleCnt;
    w_togCntNext    = r_togCnt;
    w_runCntNext    = r_runCnt;
    w_lastDirNext   = r_lastDir;
    if (!en) begin
      w_lockedNext    = 1'b0;
      w_settleCntNext = '0;
      w_togCntNext    = '0;
      w_runCntNext    = '0;
      w_lastDirNext   = DIR_NONE;
    end else begin
      if (w_settleDone) begin
        w_lockedNext = w_exitLock;
      end else if (r_state == ST_SETTLE) begin
        w_settleCntNext = r_settleCnt - 4'd1;
      end
      if (w_step) begin
        w_settleCntNext = SETTLE_LAST;
        w_lastDirNext   = w_dir;
        if (w_up) begin
          if (r_code != CRS_CODE_MAX) w_codeNext = r_code + 8'd1;
        end else begin
          if (r_code != '0) w_codeNext = r_code - 8'd1;
        end
        if (r_lastDir == DIR_NONE) begin
          w_togCntNext = '0;
          w_runCntNext = 3'd1;
        end else if (r_lastDir != w_dir) begin
          w_togCntNext = (r_togCnt == 3'd7) ? r_togCnt : (r_togCnt + 3'd1);
          w_runCntNext = 3'd1;
        end else begin
          w_togCntNext = '0;
          w_runCntNext = (r_runCnt == 3'd7) ? r_runCnt : (r_runCnt + 3'd1);
          if (r_runCnt >= UNLOCK_PRE) w_lockedNext = 1'b0;
        end
      end
    end
  end

  // Datapath and output registers; Gray and saturation flags are derived from
  // the next code so they change on the same edge as bin_code.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_code      <= INIT_CODE;
      r_gry       <= bin2gry(INIT_CODE);
      r_locked    <= 1'b0;
      r_busy      <= 1'b0;
      r_satHi     <= (INIT_CODE == CRS_CODE_MAX);
      r_satLo     <= (INIT_CODE == '0);
      r_settleCnt <= '0;
      r_togCnt    <= '0;
      r_runCnt    <= '0;
      r_lastDir   <= DIR_NONE;
    end else begin
      r_code      <= w_codeNext;
      r_gry       <= bin2gry(w_codeNext);
      r_locked    <= w_lockedNext;
      r_busy      <= (w_stateNext == ST_SETTLE);
      r_satHi     <= (w_codeNext == CRS_CODE_MAX);
      r_satLo     <= (w_codeNext == '0);
      r_settleCnt <= w_settleCntNext;
      r_togCnt    <= w_togCntNext;
      r_runCnt    <= w_runCntNext;
      r_lastDir   <= w_lastDirNext;
    end
  end

  assign bin_code = r_code;
  assign gry      = r_gry;
  assign locked   = r_locked;
  assign busy     = r_busy;
  assign sat_hi   = r_satHi;
  assign sat_lo   = r_satLo;

endmodule
